branch_sequencer: RTL and testbench

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer_pkg.sv | 27 ++
 rtl/branch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_branch_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_pkg.sv
// Shared core definitions for the branch path: branch condition codes
// (common with the external branch comparator and the decoder) and the
// sequencer state encoding.
package branch_sequencer_pkg;

    typedef enum logic [3:0] {
        BR_EQ  = 4'd0,
        BR_NE  = 4'd1,
        BR_LT  = 4'd2,
        BR_LTU = 4'd3,
        BR_GE  = 4'd4,
        BR_GEU = 4'd5
    } br_code_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } seq_state_t;

    // Codes above BR_GEU are reserved and resolve as not-taken with an error.
    function automatic logic is_legal_code(input logic [3:0] code);
        return code <= 4'(BR_GEU);
    endfunction

endpackage

// File: rtl/branch_sequencer.sv
// branch_sequencer: captures one conditional-branch request, resolves it
// through the external branch comparator, reports the outcome and, on a
// mispredict, issues a redirect followed by a fixed-length pipeline flush.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (accepted only in IDLE)
//   req_ctrl/a/b/pc/imm         branch code, operands, branch PC, signed offset
//   req_pred_taken              predictor outcome for this branch
//   cmp_a/cmp_b/cmp_ctrl        operands to the external comparator (captured)
//   cmp_flag                    combinational comparator result
//   res_valid/taken/mispred/err one-cycle resolve pulse and its qualifiers
//   redir_valid/ready, redir_pc redirect handshake and target
//   flush                       flush hold, FLUSH_CYCLES cycles after redirect
//   busy                        high whenever not IDLE
//   br_count, mispred_count     saturating statistics counters
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int BIT_WIDTH    = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_ctrl,
    input  logic [BIT_WIDTH-1:0] req_a,
    input  logic [BIT_WIDTH-1:0] req_b,
    input  logic [BIT_WIDTH-1:0] req_pc,
    input  logic [BIT_WIDTH-1:0] req_imm,
    input  logic                 req_pred_taken,

    output logic [BIT_WIDTH-1:0] cmp_a,
    output logic [BIT_WIDTH-1:0] cmp_b,
    output logic [3:0]           cmp_ctrl,
    input  logic                 cmp_flag,

    output logic                 res_valid,
    output logic                 res_taken,
    output logic                 res_mispred,
    output logic                 res_err,

    output logic                 redir_valid,
    input  logic                 redir_ready,
    output logic [BIT_WIDTH-1:0] redir_pc,

    output logic                 flush,
    output logic                 busy,

    output logic [CNT_WIDTH-1:0] br_count,
    output logic [CNT_WIDTH-1:0] mispred_count
);

    seq_state_t state, state_next;

    logic [3:0]           cap_ctrl;
    logic [BIT_WIDTH-1:0] cap_a, cap_b, cap_pc, cap_imm;
    logic                 cap_pred;
    logic [3:0]           flush_cnt;
    logic                 ready_en;

    logic                 legal;
    logic                 taken;
    logic                 mispred;
    logic [BIT_WIDTH-1:0] target;
    logic                 accept;

    // Resolution terms, meaningful only while in EVAL.
    always_comb begin
        legal   = is_legal_code(cap_ctrl);
        taken   = legal && cmp_flag;
        mispred = (taken != cap_pred);
        target  = taken ? (cap_pc + cap_imm) : (cap_pc + BIT_WIDTH'(4));
    end

    assign accept = req_valid && req_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:     if (accept) state_next = ST_EVAL;
            ST_EVAL:     state_next = mispred ? ST_REDIRECT : ST_IDLE;
            ST_REDIRECT: if (redir_ready) state_next = ST_FLUSH;
            ST_FLUSH:    if (flush_cnt <= 4'd1) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        // ready_en keeps req_ready low until the first edge after reset release.
        req_ready   = (state == ST_IDLE) && ready_en;
        busy        = (state != ST_IDLE);
        res_valid   = (state == ST_EVAL);
        res_taken   = (state == ST_EVAL) && taken;
        res_mispred = (state == ST_EVAL) && mispred;
        res_err     = (state == ST_EVAL) && !legal;
        redir_valid = (state == ST_REDIRECT);
        flush       = (state == ST_FLUSH);
    end

    assign cmp_a    = cap_a;
    assign cmp_b    = cap_b;
    assign cmp_ctrl = cap_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_ctrl <= '0;
            cap_a    <= '0;
            cap_b    <= '0;
            cap_pc   <= '0;
            cap_imm  <= '0;
            cap_pred <= 1'b0;
        end else if (accept) begin
            cap_ctrl <= req_ctrl;
            cap_a    <= req_a;
            cap_b    <= req_b;
            cap_pc   <= req_pc;
            cap_imm  <= req_imm;
            cap_pred <= req_pred_taken;
        end
    end

    // Redirect target is loaded only on a mispredict so it stays put in REDIRECT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           redir_pc <= '0;
        else if (state == ST_EVAL && mispred) redir_pc <= target;
    end

    // Flush down-counter: loaded on redirect handshake, counts FLUSH cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (state == ST_REDIRECT && redir_ready) begin
            flush_cnt <= 4'(FLUSH_CYCLES);
        end else if (state == ST_FLUSH && flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    // Saturating statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (res_valid && br_count != '1)
                br_count <= br_count + CNT_WIDTH'(1);
            if (res_mispred && mispred_count != '1)
                mispred_count <= mispred_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed self-checking bench for branch_sequencer. The external branch
// comparator is modelled here; reserved codes return 1 so the sequencer's
// own illegal-code masking is exercised.
module tb_branch_sequencer;

    localparam int BW = 32;
    localparam int CW = 4;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [3:0]    req_ctrl;
    logic [BW-1:0] req_a, req_b, req_pc, req_imm;
    logic          req_pred_taken;
    logic [BW-1:0] cmp_a, cmp_b;
    logic [3:0]    cmp_ctrl;
    logic          cmp_flag;
    logic          res_valid, res_taken, res_mispred, res_err;
    logic          redir_valid, redir_ready;
    logic [BW-1:0] redir_pc;
    logic          flush, busy;
    logic [CW-1:0] br_count, mispred_count;

    branch_sequencer #(.BIT_WIDTH(BW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
        .req_a(req_a), .req_b(req_b), .req_pc(req_pc), .req_imm(req_imm),
        .req_pred_taken(req_pred_taken),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_ctrl(cmp_ctrl), .cmp_flag(cmp_flag),
        .res_valid(res_valid), .res_taken(res_taken), .res_mispred(res_mispred),
        .res_err(res_err),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .flush(flush), .busy(busy),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    // Comparator model
    always_comb begin
        case (cmp_ctrl)
            4'd0:    cmp_flag = (cmp_a == cmp_b);
            4'd1:    cmp_flag = (cmp_a != cmp_b);
            4'd2:    cmp_flag = ($signed(cmp_a) <  $signed(cmp_b));
            4'd3:    cmp_flag = (cmp_a <  cmp_b);
            4'd4:    cmp_flag = ($signed(cmp_a) >= $signed(cmp_b));
            4'd5:    cmp_flag = (cmp_a >= cmp_b);
            default: cmp_flag = 1'b1;
        endcase
    end

    int errors = 0;
    int checks = 0;
    int exp_br = 0;
    int exp_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]    ctrl;
        logic [BW-1:0] a, b, pc, imm;
        logic          pred;
        logic          e_taken, e_mis, e_err;
        logic [BW-1:0] e_redir;
    } vec_t;

    vec_t vecs[9];

    task automatic bump(input logic mis);
        if (exp_br < 15) exp_br++;
        if (mis && exp_mis < 15) exp_mis++;
    endtask

    // Called on a negedge in IDLE; returns on the negedge inside EVAL.
    task automatic send(input logic [3:0] c, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic [BW-1:0] pc, input logic [BW-1:0] imm, input logic p);
        chk("ready_before_send", 32'(req_ready), 32'd1);
        req_ctrl = c; req_a = a; req_b = b; req_pc = pc; req_imm = imm;
        req_pred_taken = p; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_a = '1; req_b = '0; req_ctrl = 4'd1;  // scramble: cmp_* must use captured values
    endtask

    task automatic run_vec(input vec_t v);
        send(v.ctrl, v.a, v.b, v.pc, v.imm, v.pred);
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_taken", 32'(res_taken), 32'(v.e_taken));
        chk("res_mispred", 32'(res_mispred), 32'(v.e_mis));
        chk("res_err", 32'(res_err), 32'(v.e_err));
        chk("cmp_a", cmp_a, v.a);
        bump(v.e_mis);
        @(negedge clk);
        if (v.e_mis) begin
            chk("redir_valid", 32'(redir_valid), 32'd1);
            chk("redir_pc", redir_pc, v.e_redir);
            redir_ready = 1'b1;
            @(negedge clk);
            redir_ready = 1'b0;
            for (int i = 0; i < FC; i++) begin
                chk("flush_hold", 32'(flush), 32'd1);
                @(negedge clk);
            end
            chk("flush_end", 32'(flush), 32'd0);
        end else begin
            chk("no_redir", 32'(redir_valid), 32'd0);
        end
        chk("ready_after", 32'(req_ready), 32'd1);
        chk("br_count", 32'(br_count), 32'(exp_br));
        chk("mispred_count", 32'(mispred_count), 32'(exp_mis));
    endtask

    initial begin
        //          ctrl  a             b             pc            imm           pred tk mis err redir
        vecs[0] = '{4'd0, 32'd5,        32'd5,        32'h100,      32'h20,       1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{4'd1, 32'd3,        32'd3,        32'h400,      32'h10,       1'b1, 1'b0, 1'b1, 1'b0, 32'h404};
        vecs[2] = '{4'd3, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFC, 32'h8,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{4'd7, 32'd1,        32'd1,        32'h300,      32'h50,       1'b1, 1'b0, 1'b1, 1'b1, 32'h304};
        vecs[4] = '{4'd4, 32'hFFFFFFFE, 32'd1,        32'h500,      32'h10,       1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{4'd5, 32'hFFFFFFFE, 32'd1,        32'h600,      32'hFFFFFFF0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5F0};
        vecs[6] = '{4'd15,32'd9,        32'd9,        32'h700,      32'h10,       1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[7] = '{4'd2, 32'd1,        32'hFFFFFFFF, 32'h800,      32'h10,       1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{4'd0, 32'd0,        32'd0,        32'hFFFFFFF0, 32'h20,       1'b0, 1'b1, 1'b1, 1'b0, 32'h10};

        rst_n = 1'b0; req_valid = 1'b0; redir_ready = 1'b0;
        req_ctrl = '0; req_a = '0; req_b = '0; req_pc = '0; req_imm = '0; req_pred_taken = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redir_valid", 32'(redir_valid), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_br_count", 32'(br_count), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_edge", 32'(req_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // redir_ready outside REDIRECT is ignored
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk("idle_redir_ready_busy", 32'(busy), 32'd0);
        chk("idle_redir_ready_flush", 32'(flush), 32'd0);

        // Mispredicted BLT with a stalled redirect
        send(4'd2, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b0);
        chk("blt_taken", 32'(res_taken), 32'd1);
        chk("blt_mispred", 32'(res_mispred), 32'd1);
        bump(1'b1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("stall_redir_valid", 32'(redir_valid), 32'd1);
            chk("stall_redir_pc", redir_pc, 32'h240);
            chk("stall_no_flush", 32'(flush), 32'd0);
            chk("stall_not_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        chk("stall_redir_valid_last", 32'(redir_valid), 32'd1);
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk("flush1", 32'(flush), 32'd1);
        chk("flush1_busy", 32'(busy), 32'd1);
        chk("flush1_redir_valid", 32'(redir_valid), 32'd0);
        @(negedge clk);
        chk("flush2", 32'(flush), 32'd1);
        @(negedge clk);
        chk("flush_done", 32'(flush), 32'd0);
        chk("flush_done_ready", 32'(req_ready), 32'd1);
        chk("blt_mispred_count", 32'(mispred_count), 32'(exp_mis));

        // Back-to-back correctly predicted branches: one accept per 2 cycles
        req_ctrl = 4'd0; req_a = 32'd7; req_b = 32'd7; req_pc = 32'h900;
        req_imm = 32'h8; req_pred_taken = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ready", 32'(req_ready), 32'((i % 2) == 0));
            chk("b2b_res_valid", 32'(res_valid), 32'((i % 2) == 1));
            if (i == 3) req_valid = 1'b0;
            @(negedge clk);
        end
        bump(1'b0); bump(1'b0);
        chk("b2b_br_count", 32'(br_count), 32'(exp_br));
        chk("b2b_idle", 32'(busy), 32'd0);

        // Reset during FLUSH abandons the operation
        send(4'd1, 32'd1, 32'd1, 32'hA00, 32'h0, 1'b1);
        @(negedge clk);
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk("pre_rst_flush", 32'(flush), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_flush", 32'(flush), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_br_count", 32'(br_count), 32'd0);
        chk("mid_rst_mis_count", 32'(mispred_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_br = 0; exp_mis = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_redir", 32'(redir_valid), 32'd0);
            chk("post_rst_flush", 32'(flush), 32'd0);
        end
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_redir_pc", redir_pc, 32'd0);

        // 17 mispredicts saturate both 4-bit counters at 15
        for (int i = 0; i < 17; i++) begin
            vec_t v;
            v = '{4'd0, 32'd1, 32'd2, 32'(i * 16), 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'(i * 16 + 4)};
            run_vec(v);
        end
        chk("sat_br_count", 32'(br_count), 32'd15);
        chk("sat_mispred_count", 32'(mispred_count), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
